axi_stream_crc_gen: RTL and testbench
=====================================

AXI_STREAM_CRC_GEN -- requirements
Module: axi_stream_crc_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512: tdata width in bits, a multiple of 8, at least 8.
REQ-002 SHALL have parameter KEEP_BYTES, default DATA_WIDTH/8: tkeep width and byte lanes per beat.
REQ-003 SHALL have parameter CRC_WIDTH, default 32: CRC width; only the value 32 is supported.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port srst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_s_tdata, input, DATA_WIDTH bits: source data; byte lane n is bits [8n+7:8n].
REQ-007 SHALL have port i_s_tkeep, input, KEEP_BYTES bits: source byte enables.
REQ-008 SHALL have port i_s_tlast, input, 1 bit: source end-of-packet.
REQ-009 SHALL have port i_s_tvalid, input, 1 bit: source valid.
REQ-010 SHALL have port o_s_tready, output, 1 bit: ready to source.
REQ-011 SHALL have port o_m_tdata, output, DATA_WIDTH bits: registered data to sink.
REQ-012 SHALL have port o_m_tkeep, output, KEEP_BYTES bits: registered byte enables to sink.
REQ-013 SHALL have port o_m_tlast, output, 1 bit: registered end-of-packet.
REQ-014 SHALL have port o_m_tvalid, output, 1 bit: valid to sink.
REQ-015 SHALL have port i_m_tready, input, 1 bit: ready from sink.
REQ-016 SHALL have port crc, output, CRC_WIDTH+1 bits: sideband; bit CRC_WIDTH = CRC valid, bits [CRC_WIDTH-1:0] = CRC value.

Function
REQ-017 SHALL accept a source beat exactly when i_s_tvalid and o_s_tready are both 1 on a rising edge.
REQ-018 SHALL drive o_s_tready = !srst && (!o_m_tvalid || i_m_tready), giving full throughput with a combinational ready path.
REQ-019 SHALL present an accepted beat on the o_m_* outputs on the next cycle (latency 1), with tdata, tkeep and tlast unmodified.
REQ-020 SHALL keep the output register and o_m_tvalid stable while o_m_tvalid=1 and i_m_tready=0.
REQ-021 SHALL clear o_m_tvalid after a cycle with o_m_tvalid && i_m_tready when no new beat is accepted in that cycle.
REQ-022 SHALL compute CRC-32/IEEE: reflected, polynomial 0x04C11DB7 (reflected form 0xEDB88320), init 0xFFFFFFFF, final XOR 0xFFFFFFFF.
REQ-023 SHALL feed bytes in lane order 0 to KEEP_BYTES-1 within a beat and in beat order across beats, skipping every lane whose tkeep bit is 0 (sparse keep allowed).
REQ-024 SHALL hold the running CRC register; on each accepted non-last beat it is updated with that beat's kept bytes.
REQ-025 SHALL, on an accepted tlast beat, compute final = ~CRC(running, kept bytes of this beat), and reload the running register with 0xFFFFFFFF.
REQ-026 SHALL register crc = {1'b1, final} together with the tlast beat, and crc = {1'b0, 32'h0} with every non-last beat.
REQ-027 SHALL keep crc stable under backpressure, following REQ-020.
REQ-028 SHALL treat a beat with tkeep = 0 as contributing no bytes; a first-and-last beat with keep 0 gives final 0x00000000.
REQ-029 SHALL allow back-to-back packets (tlast beat followed immediately by the next packet's first beat) with no bubble and no CRC carry-over.

Reset
REQ-030 SHALL, while srst=1 at a rising edge, clear o_m_tvalid, o_m_tlast, o_m_tdata, o_m_tkeep and crc to 0, and set the running CRC to 0xFFFFFFFF.
REQ-031 SHALL discard a partial packet on reset mid-packet: no output is generated for it, and the first beat accepted after reset starts a fresh CRC.
REQ-032 SHALL hold o_s_tready = 0 while srst = 1.

Verification (DATA_WIDTH = 64)
REQ-033 Check vector: beat 0x3837363534333231, keep 0xFF, no tlast; then beat 0x39, keep 0x01, tlast; sink always ready -> second output beat carries crc = {1, 0xCBF43926}, first beat carries crc = {0, 0}.
REQ-034 Same packet with i_m_tready held 0 for 5 cycles at each beat -> outputs stay stable, no beat is lost or duplicated, same CRC result.
REQ-035 Single beat, keep 0x00, tlast -> crc = {1, 0x00000000}; next packet REQ-033 back-to-back -> 0xCBF43926.
REQ-036 Sparse keep: beat 0x3900383736353433_0 layout with bytes "123456789" spread by keep 0xAF-style masking (only kept lanes holding the string in order) -> 0xCBF43926.
REQ-037 srst pulsed after the first beat of REQ-033 -> o_m_tvalid = 0 the next cycle; re-sending the full packet -> 0xCBF43926.
REQ-038 Random packets of 1-20 beats with random keep and random valid/ready -> data passes through unchanged and crc matches the reference model.

Source files
------------

// File: rtl/axi_stream_crc_gen.sv
// AXI-Stream register slice that passes beats through unchanged and emits a
// CRC-32/IEEE sideband, valid on the tlast beat of every packet.
module axi_stream_crc_gen #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_BYTES = DATA_WIDTH / 8,
  parameter int CRC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [DATA_WIDTH-1:0] i_s_tdata,
  input  logic [KEEP_BYTES-1:0] i_s_tkeep,
  input  logic                  i_s_tlast,
  input  logic                  i_s_tvalid,
  output logic                  o_s_tready,
  output logic [DATA_WIDTH-1:0] o_m_tdata,
  output logic [KEEP_BYTES-1:0] o_m_tkeep,
  output logic                  o_m_tlast,
  output logic                  o_m_tvalid,
  input  logic                  i_m_tready,
  output logic [CRC_WIDTH:0]    crc
);

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic [KEEP_BYTES-1:0] r_m_tkeep;
  logic                  r_m_tlast;
  logic                  r_m_tvalid;
  logic [CRC_WIDTH:0]    r_crc;
  logic [31:0]           r_crc_run;

  logic                  w_accept;
  logic [31:0]           w_crc_beat;
  logic [7:0]            w_lane [KEEP_BYTES];

  genvar gi;
  generate
    for (gi = 0; gi < KEEP_BYTES; gi++) begin : g_lane
      assign w_lane[gi] = i_s_tdata[8*gi +: 8];
    end
  endgenerate

  // Reflected CRC: LSB-first shift, one byte per call.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] v;
    v = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      v = v[0] ? ((v >> 1) ^ CRC_POLY_REFL) : (v >> 1);
    end
    return v;
  endfunction

  // Chain every kept lane through the byte update, lane 0 first.
  always_comb begin
    w_crc_beat = r_crc_run;
    for (int n = 0; n < KEEP_BYTES; n++) begin
      if (i_s_tkeep[n]) begin
        w_crc_beat = crc_byte(w_crc_beat, w_lane[n]);
      end
    end
  end

  assign o_s_tready = !srst && (!r_m_tvalid || i_m_tready);
  assign w_accept   = i_s_tvalid && o_s_tready;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_crc      <= '0;
      r_crc_run  <= CRC_INIT;
    end else begin
      if (w_accept) begin
        r_m_tdata  <= i_s_tdata;
        r_m_tkeep  <= i_s_tkeep;
        r_m_tlast  <= i_s_tlast;
        r_m_tvalid <= 1'b1;
        if (i_s_tlast) begin
          r_crc     <= {1'b1, ~w_crc_beat};
          r_crc_run <= CRC_INIT;
        end else begin
          r_crc     <= '0;
          r_crc_run <= w_crc_beat;
        end
      end else if (i_m_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign o_m_tdata  = r_m_tdata;
  assign o_m_tkeep  = r_m_tkeep;
  assign o_m_tlast  = r_m_tlast;
  assign o_m_tvalid = r_m_tvalid;
  assign crc        = r_crc;

endmodule

// File: tb/tb_axi_stream_crc_gen.sv
// Directed and random checks of axi_stream_crc_gen at 64-bit width, using a
// scoreboard fed at source acceptance and drained at sink handshakes.
module tb_axi_stream_crc_gen;

  localparam int DW = 64;
  localparam int KB = 8;
  localparam logic [31:0] INIT = 32'hFFFFFFFF;

  logic          clk = 1'b0;
  logic          srst;
  logic [DW-1:0] i_s_tdata;
  logic [KB-1:0] i_s_tkeep;
  logic          i_s_tlast;
  logic          i_s_tvalid;
  logic          o_s_tready;
  logic [DW-1:0] o_m_tdata;
  logic [KB-1:0] o_m_tkeep;
  logic          o_m_tlast;
  logic          o_m_tvalid;
  logic          i_m_tready;
  logic [32:0]   crc;

  always #5 clk = ~clk;

  axi_stream_crc_gen #(.DATA_WIDTH(DW), .KEEP_BYTES(KB), .CRC_WIDTH(32)) dut (
    .clk(clk), .srst(srst),
    .i_s_tdata(i_s_tdata), .i_s_tkeep(i_s_tkeep), .i_s_tlast(i_s_tlast),
    .i_s_tvalid(i_s_tvalid), .o_s_tready(o_s_tready),
    .o_m_tdata(o_m_tdata), .o_m_tkeep(o_m_tkeep), .o_m_tlast(o_m_tlast),
    .o_m_tvalid(o_m_tvalid), .i_m_tready(i_m_tready), .crc(crc)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KB-1:0] k;
    logic          l;
    logic [32:0]   c;
  } beat_t;

  beat_t       sb_q[$];
  beat_t       hold_b;
  logic        hold_vld = 1'b0;
  logic [31:0] m_run = INIT;
  logic [32:0] last_crc_out = '0;
  logic        src_acc = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_acc   = 0;
  int          n_out   = 0;
  int          n_disc  = 0;
  int          rdy_mode = 0;
  logic        rdy_force = 1'b1;
  int          rdy_cnt = 0;

  // Bit-serial reflected CRC-32 reference over the kept lanes of one beat.
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [DW-1:0] d,
                                          input logic [KB-1:0] k);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int n = 0; n < KB; n++) begin
      if (k[n]) begin
        for (int i = 0; i < 8; i++) begin
          fb = r[0] ^ d[8*n+i];
          r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge (monitor + model), then drive sink ready after posedge.
  task automatic tick();
    beat_t b;
    beat_t e;
    @(negedge clk);
    src_acc = 1'b0;
    if (srst) begin
      n_disc  += sb_q.size();
      sb_q.delete();
      m_run    = INIT;
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        chk("stall_stable", {o_m_tvalid, o_m_tdata, o_m_tkeep, o_m_tlast, crc},
            {1'b1, hold_b.d, hold_b.k, hold_b.l, hold_b.c});
      end
      if (o_m_tvalid && i_m_tready) begin
        chk("sb_nonempty", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("tdata", o_m_tdata, e.d);
          chk("tkeep", o_m_tkeep, e.k);
          chk("tlast", o_m_tlast, e.l);
          chk("crc",   crc,       e.c);
          $display("[TB] out beat data=%016h keep=%02h last=%0b crc=%09h", o_m_tdata, o_m_tkeep,
                   o_m_tlast, crc);
        end
        if (o_m_tlast) last_crc_out = crc;
        n_out++;
        hold_vld = 1'b0;
      end else if (o_m_tvalid) begin
        hold_vld = 1'b1;
        hold_b.d = o_m_tdata;
        hold_b.k = o_m_tkeep;
        hold_b.l = o_m_tlast;
        hold_b.c = crc;
      end else begin
        hold_vld = 1'b0;
      end
      if (i_s_tvalid && o_s_tready) begin
        src_acc = 1'b1;
        n_acc++;
        b.d   = i_s_tdata;
        b.k   = i_s_tkeep;
        b.l   = i_s_tlast;
        m_run = ref_crc(m_run, i_s_tdata, i_s_tkeep);
        if (i_s_tlast) begin
          b.c   = {1'b1, ~m_run};
          m_run = INIT;
        end else begin
          b.c = '0;
        end
        sb_q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       i_m_tready = ($urandom_range(0, 1) == 1);
      2: begin rdy_cnt++; i_m_tready = ((rdy_cnt % 6) == 5); end
      default: i_m_tready = rdy_force;
    endcase
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KB-1:0] k, input logic l);
    i_s_tdata  = d;
    i_s_tkeep  = k;
    i_s_tlast  = l;
    i_s_tvalid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (src_acc) break;
    end
    chk("src_accept", src_acc, 1);
  endtask

  task automatic drain();
    i_s_tvalid = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (sb_q.size() == 0 && !o_m_tvalid) break;
      tick();
    end
    chk("drain_empty", sb_q.size(), 0);
  endtask

  int nb;

  initial begin
    srst       = 1'b1;
    i_s_tdata  = '0;
    i_s_tkeep  = '0;
    i_s_tlast  = 1'b0;
    i_s_tvalid = 1'b0;
    i_m_tready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_tready", o_s_tready, 0);
    chk("rst_tvalid", o_m_tvalid, 0);
    chk("rst_tdata",  o_m_tdata, 0);
    chk("rst_tkeep",  o_m_tkeep, 0);
    chk("rst_tlast",  o_m_tlast, 0);
    chk("rst_crc",    crc, 0);
    srst = 1'b0;
    tick();
    chk("post_rst_tready", o_s_tready, 1);

    // Check vector "123456789", sink always ready
    send_beat(64'h3837363534333231, 8'hFF, 1'b0);
    send_beat(64'h39, 8'h01, 1'b1);
    drain();
    chk("check_vector", last_crc_out, 33'h1CBF43926);

    // Same packet under heavy backpressure
    rdy_mode = 2;
    send_beat(64'h3837363534333231, 8'hFF, 1'b0);
    send_beat(64'h39, 8'h01, 1'b1);
    drain();
    rdy_mode = 0;
    chk("backpressure_crc", last_crc_out, 33'h1CBF43926);

    // Empty keep packet, then check vector back-to-back
    send_beat(64'hDEADBEEFCAFEF00D, 8'h00, 1'b1);
    send_beat(64'h3837363534333231, 8'hFF, 1'b0);
    send_beat(64'h39, 8'h01, 1'b1);
    drain();
    chk("b2b_crc", last_crc_out, 33'h1CBF43926);

    send_beat(64'h1122334455667788, 8'h00, 1'b1);
    drain();
    chk("keep0_crc", last_crc_out, 33'h100000000);

    // Sparse keep, string spread over kept lanes only
    send_beat(64'h36BB35AA34333231, 8'hAF, 1'b0);
    send_beat(64'hEEEEEE39DD38CC37, 8'h15, 1'b1);
    drain();
    chk("sparse_crc", last_crc_out, 33'h1CBF43926);

    // Reset mid-packet with the first beat still held in the output register
    rdy_force = 1'b0;
    send_beat(64'h3837363534333231, 8'hFF, 1'b0);
    i_s_tvalid = 1'b0;
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("midrst_tvalid", o_m_tvalid, 0);
    rdy_force = 1'b1;
    tick();
    send_beat(64'h3837363534333231, 8'hFF, 1'b0);
    send_beat(64'h39, 8'h01, 1'b1);
    drain();
    chk("midrst_crc", last_crc_out, 33'h1CBF43926);

    // Random packets with random gaps and random sink ready
    rdy_mode = 1;
    for (int p = 0; p < 30; p++) begin
      nb = $urandom_range(1, 20);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          i_s_tvalid = 1'b0;
          tick();
        end
        send_beat({$urandom, $urandom}, 8'($urandom), (b == nb - 1));
      end
    end
    drain();
    rdy_mode = 0;
    chk("beat_count", n_out + n_disc, n_acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
